instr_encoder: RTL and testbench

Streaming instruction encoder for the SIMD AES core's program-load path. It accepts opcode, immediate and base-field requests over a valid/ready handshake. It range-checks each immediate against its opcode's format and scatters the bits into the 30-bit instruction word exactly as the decode-side immediate generator expects to gather them. Accepted words are written sequentially into instruction memory from a programmed base address. Out-of-range requests are dropped and counted.

---
 rtl/instr_enc_pkg.sv | 39 +++
 rtl/instr_imm_pack.sv | 58 +++++
 rtl/instr_encoder.sv | 139 +++++++++++++
 tb/tb_instr_encoder.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_enc_pkg.sv
// Shared definitions for the program-load instruction encoder.
// Holds the instruction field widths, the opcodes that carry an immediate,
// the range masks used to validate immediates, and the encoder FSM states.
package instr_enc_pkg;

    localparam int INSTR_W = 30;
    localparam int OPC_W   = 5;
    localparam int P1_W    = 15;
    localparam int P2_W    = 10;
    localparam int BASE_W  = P1_W + P2_W;
    localparam int IMM_W   = 32;

    localparam logic [OPC_W-1:0] OP_LDI_A = 5'b10111;
    localparam logic [OPC_W-1:0] OP_LDI_B = 5'b10010;
    localparam logic [OPC_W-1:0] OP_IMM17 = 5'b01000;
    localparam logic [OPC_W-1:0] OP_BR12  = 5'b11000;
    localparam logic [OPC_W-1:0] OP_IMM15 = 5'b00100;

    // Bits that must be all-zero (unsigned) or all-equal (signed) for the
    // immediate to fit its field.
    localparam logic [IMM_W-1:0] MASK_U10 = 32'hFFFF_FC00;
    localparam logic [IMM_W-1:0] MASK_S17 = 32'hFFFF_0000;
    localparam logic [IMM_W-1:0] MASK_S12 = 32'hFFFF_F800;
    localparam logic [IMM_W-1:0] MASK_S15 = 32'hFFFF_C000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } enc_state_e;

    // A signed value fits when the masked upper bits are a pure sign
    // extension: either all ones or all zeros.
    function automatic logic sext_fits(input logic [IMM_W-1:0] v,
                                       input logic [IMM_W-1:0] mask);
        return ((v & mask) == mask) || ((v & mask) == '0);
    endfunction

endpackage

// File: rtl/instr_imm_pack.sv
// Combinational immediate packer.
// Scatters an immediate into the {OpCode, P1, P2} instruction word in the
// layout the decode-side immediate generator gathers from, and flags
// immediates that do not fit the opcode's format.
// Ports:
//   opcode_i    opcode field, MSB-first
//   imm_i       two's-complement immediate
//   base_i      {P1, P2} template supplying every non-immediate bit
//   word_o      packed 30-bit instruction word
//   range_err_o immediate out of range for this opcode
module instr_imm_pack
    import instr_enc_pkg::*;
(
    input  logic [OPC_W-1:0]   opcode_i,
    input  logic [IMM_W-1:0]   imm_i,
    input  logic [BASE_W-1:0]  base_i,
    output logic [INSTR_W-1:0] word_o,
    output logic               range_err_o
);

    // p1[14] is P1[0] and p2[9] is P2[0]: fields are numbered MSB-first,
    // so field index i lives at vector bit (width-1-i).
    logic [P1_W-1:0] p1;
    logic [P2_W-1:0] p2;

    always_comb begin
        p1          = base_i[BASE_W-1:P2_W];
        p2          = base_i[P2_W-1:0];
        range_err_o = 1'b0;
        unique case (opcode_i)
            OP_LDI_A, OP_LDI_B: begin
                p2          = imm_i[9:0];
                range_err_o = |(imm_i & MASK_U10);
            end
            OP_IMM17: begin
                p1[14:8]    = imm_i[16:10];
                p2          = imm_i[9:0];
                range_err_o = !sext_fits(imm_i, MASK_S17);
            end
            OP_BR12: begin
                // Branch layout splits the top two bits away from the rest:
                // P1[0]=imm[11], P2[4]=imm[10], P1[1:6]=imm[9:4], P2[0:3]=imm[3:0].
                p1[14]      = imm_i[11];
                p2[5]       = imm_i[10];
                p1[13:8]    = imm_i[9:4];
                p2[9:6]     = imm_i[3:0];
                range_err_o = !sext_fits(imm_i, MASK_S12);
            end
            OP_IMM15: begin
                p1          = imm_i[14:0];
                range_err_o = !sext_fits(imm_i, MASK_S15);
            end
            default: ;
        endcase
        word_o = {opcode_i, p1, p2};
    end

endmodule

// File: rtl/instr_encoder.sv
// Streaming instruction encoder for the program-load path.
// A start in IDLE latches a base address and a request count; each accepted
// request is range-checked and packed, and in-range words are written to
// consecutive memory addresses one cycle after acceptance. Out-of-range
// requests consume count but produce no write, and are counted.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start, base_addr,   burst launch (IDLE only), first address,
//   count               number of requests to consume
//   in_valid/in_ready   request handshake
//   in_opcode, in_imm,  request fields
//   in_base
//   mem_we, mem_addr,   registered instruction-memory write port
//   mem_wdata
//   busy, done          state != IDLE, one-cycle end-of-burst pulse
//   err, err_cnt        sticky range error, rejected requests this burst
module instr_encoder
    import instr_enc_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [ADDR_W:0]     count,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [OPC_W-1:0]    in_opcode,
    input  logic [IMM_W-1:0]    in_imm,
    input  logic [BASE_W-1:0]   in_base,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [INSTR_W-1:0]  mem_wdata,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [ADDR_W:0]     err_cnt
);

    localparam logic [ADDR_W:0]   CNT_ONE = 1;
    localparam logic [ADDR_W-1:0] PTR_ONE = 1;

    enc_state_e          state_q, state_d;
    logic [ADDR_W:0]     remaining_q, remaining_d;
    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [INSTR_W-1:0]  mem_wdata_q, mem_wdata_d;
    logic                err_q, err_d;
    logic [ADDR_W:0]     err_cnt_q, err_cnt_d;

    logic [INSTR_W-1:0]  pack_word;
    logic                pack_err;
    logic                accept;

    instr_imm_pack u_pack (
        .opcode_i    (in_opcode),
        .imm_i       (in_imm),
        .base_i      (in_base),
        .word_o      (pack_word),
        .range_err_o (pack_err)
    );

    assign in_ready = (state_q == ST_RUN) && (remaining_q != '0);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        wr_ptr_d    = wr_ptr_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        err_d       = err_q;
        err_cnt_d   = err_cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d     = ST_RUN;
                    wr_ptr_d    = base_addr;
                    remaining_d = count;
                    err_d       = 1'b0;
                    err_cnt_d   = '0;
                end
            end
            ST_RUN: begin
                if (accept) begin
                    remaining_d = remaining_q - CNT_ONE;
                    if (pack_err) begin
                        err_d     = 1'b1;
                        err_cnt_d = err_cnt_q + CNT_ONE;
                    end else begin
                        mem_we_d    = 1'b1;
                        mem_addr_d  = wr_ptr_q;
                        mem_wdata_d = pack_word;
                        wr_ptr_d    = wr_ptr_q + PTR_ONE;
                    end
                end
                // Looking at the post-decrement count lets DONE coincide
                // with the final write instead of trailing it.
                if (remaining_d == '0) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            remaining_q <= '0;
            wr_ptr_q    <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            err_q       <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            wr_ptr_q    <= wr_ptr_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            err_q       <= err_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign err       = err_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed scoreboard bench for instr_encoder.
module tb_instr_encoder;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  base_addr;
    logic [8:0]  count;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_opcode;
    logic [31:0] in_imm;
    logic [24:0] in_base;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [29:0] mem_wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [8:0]  err_cnt;

    instr_encoder #(.ADDR_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .count     (count),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_opcode (in_opcode),
        .in_imm    (in_imm),
        .in_base   (in_base),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .err_cnt   (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  addr;
        logic [29:0] data;
    } wr_t;

    wr_t         sb[$];
    wr_t         wlog[$];
    int          total = 0;
    int          bad = 0;
    int          we_run = 0;
    int          we_run_max = 0;
    logic [7:0]  exp_ptr = 8'h00;
    logic [29:0] br_word = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference packer, written field-by-field with MSB-first indices.
    function automatic logic [29:0] model(input logic [4:0] op, input logic [31:0] imm,
                                          input logic [24:0] base);
        logic p1 [0:14];
        logic p2 [0:9];
        logic [29:0] w;
        for (int i = 0; i < 15; i++) p1[i] = base[24-i];
        for (int j = 0; j < 10; j++) p2[j] = base[9-j];
        case (op)
            5'b10111, 5'b10010: for (int j = 0; j < 10; j++) p2[j] = imm[9-j];
            5'b01000: begin
                for (int i = 0; i < 7; i++) p1[i] = imm[16-i];
                for (int j = 0; j < 10; j++) p2[j] = imm[9-j];
            end
            5'b11000: begin
                p1[0] = imm[11];
                p2[4] = imm[10];
                for (int i = 1; i < 7; i++) p1[i] = imm[10-i];
                for (int j = 0; j < 4; j++) p2[j] = imm[3-j];
            end
            5'b00100: for (int i = 0; i < 15; i++) p1[i] = imm[14-i];
            default: ;
        endcase
        w[29:25] = op;
        for (int i = 0; i < 15; i++) w[24-i] = p1[i];
        for (int j = 0; j < 10; j++) w[9-j] = p2[j];
        return w;
    endfunction

    // Decode-side gather for the branch format, sign-extended to 32 bits.
    function automatic logic [31:0] decode_br(input logic [29:0] w);
        logic [11:0] v;
        v = {w[24], w[5], w[23:18], w[9:6]};
        return {{20{v[11]}}, v};
    endfunction

    // Scoreboard: every write is popped and compared in order.
    always @(negedge clk) begin
        if (mem_we) begin
            wr_t e;
            we_run++;
            if (we_run > we_run_max) we_run_max = we_run;
            wlog.push_back('{mem_addr, mem_wdata});
            if (mem_wdata[29:25] == 5'b11000) br_word = mem_wdata;
            total++;
            assert (sb.size() != 0) else begin
                bad++;
                $error("FAIL unexpected_write observed addr=%0h data=%0h expected=no write",
                       mem_addr, mem_wdata);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("wr_addr", {24'h0, mem_addr}, {24'h0, e.addr});
                chk("wr_data", {2'b0, mem_wdata}, {2'b0, e.data});
            end
        end else begin
            we_run = 0;
        end
    end

    task automatic check_reset(input string tag);
        chk({tag, "_in_ready"},  {31'h0, in_ready}, 32'h0);
        chk({tag, "_mem_we"},    {31'h0, mem_we},   32'h0);
        chk({tag, "_done"},      {31'h0, done},     32'h0);
        chk({tag, "_busy"},      {31'h0, busy},     32'h0);
        chk({tag, "_err"},       {31'h0, err},      32'h0);
        chk({tag, "_mem_addr"},  {24'h0, mem_addr}, 32'h0);
        chk({tag, "_mem_wdata"}, {2'b0, mem_wdata}, 32'h0);
        chk({tag, "_err_cnt"},   {23'h0, err_cnt},  32'h0);
    endtask

    task automatic start_burst(input logic [7:0] ba, input logic [8:0] cnt);
        @(negedge clk);
        start     = 1'b1;
        base_addr = ba;
        count     = cnt;
        exp_ptr   = ba;
        wlog.delete();
        @(negedge clk);
        start = 1'b0;
        chk("start_busy", {31'h0, busy}, 32'h1);
        chk("start_err_clear", {31'h0, err}, 32'h0);
    endtask

    // Drives a request and returns at the negedge just before it is accepted.
    task automatic send(input logic [4:0] op, input logic [31:0] imm,
                        input logic [24:0] base, input logic expect_write);
        int n;
        @(negedge clk);
        in_valid  = 1'b1;
        in_opcode = op;
        in_imm    = imm;
        in_base   = base;
        n = 0;
        while (!in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", {31'h0, in_ready}, 32'h1);
        if (expect_write) begin
            sb.push_back('{exp_ptr, model(op, imm, base)});
            exp_ptr = exp_ptr + 8'h01;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("idle_wait", {31'h0, busy}, 32'h0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; base_addr = '0; count = '0;
        in_valid = 1'b0; in_opcode = '0; in_imm = '0; in_base = '0;
        repeat (2) @(negedge clk);
        check_reset("rst");
        rst = 1'b0;

        // Two-word burst; done coincides with the final write.
        start_burst(8'h10, 9'd2);
        send(5'b10111, 32'h0000_03FF, 25'h0, 1'b1);
        send(5'b00100, 32'hFFFF_FFFF, 25'h0, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("t1_last_we",    {31'h0, mem_we}, 32'h1);
        chk("t1_last_done",  {31'h0, done},   32'h1);
        chk("t1_last_ready", {31'h0, in_ready}, 32'h0);
        chk("t1_last_addr",  {24'h0, mem_addr}, 32'h11);
        chk("t1_last_data",  {2'b0, mem_wdata}, 32'h09FF_FC00);
        @(negedge clk);
        chk("t1_done_drop", {31'h0, done}, 32'h0);
        chk("t1_idle",      {31'h0, busy}, 32'h0);
        chk("t1_w0_data",   {2'b0, wlog[0].data}, 32'h2E00_03FF);
        chk("t1_w0_addr",   {24'h0, wlog[0].addr}, 32'h10);

        // Zero-length burst: RUN then DONE, no writes.
        start_burst(8'h30, 9'd0);
        chk("z_ready", {31'h0, in_ready}, 32'h0);
        @(negedge clk);
        chk("z_done", {31'h0, done}, 32'h1);
        @(negedge clk);
        chk("z_idle", {31'h0, busy}, 32'h0);
        chk("z_nowrite", wlog.size(), 32'd0);

        // Branch pack, out-of-range reject, next word reuses the address.
        start_burst(8'h20, 9'd3);
        send(5'b11000, 32'hFFFF_F800, 25'h0, 1'b1);
        send(5'b01000, 32'd65536, 25'h0, 1'b0);
        send(5'b10111, 32'd5, 25'h155_5555, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        wait_idle();
        chk("t2_err",     {31'h0, err}, 32'h1);
        chk("t2_err_cnt", {23'h0, err_cnt}, 32'h1);
        chk("t2_nwrites", wlog.size(), 32'd2);
        chk("t2_br_p1",   {17'h0, wlog[0].data[24:10]}, 32'h4000);
        chk("t2_br_p2",   {22'h0, wlog[0].data[9:0]}, 32'h0);
        chk("t2_br_rt",   decode_br(br_word), 32'hFFFF_F800);
        chk("t2_reuse_addr", {24'h0, wlog[1].addr}, 32'h21);

        // Address wrap at the top of memory.
        start_burst(8'hFE, 9'd3);
        send(5'b10010, 32'd7, 25'h0AB_CDEF, 1'b1);
        send(5'b00100, 32'd100, 25'h123_4567, 1'b1);
        send(5'b00001, 32'hDEAD_BEEF, 25'h1FF_00FF, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("t3_wrap_addr", {24'h0, mem_addr}, 32'h00);
        chk("t3_wrap_done", {31'h0, done}, 32'h1);
        wait_idle();
        chk("t3_w0", {24'h0, wlog[0].addr}, 32'hFE);
        chk("t3_w1", {24'h0, wlog[1].addr}, 32'hFF);

        // Back-to-back stream; a start during RUN must be ignored.
        start_burst(8'h40, 9'd4);
        we_run_max = 0;
        send(5'b10010, 32'd1, 25'h0, 1'b1);
        start = 1'b1; base_addr = 8'h99; count = 9'd7;
        send(5'b10010, 32'd2, 25'h1, 1'b1);
        send(5'b10010, 32'd1023, 25'h2, 1'b1);
        send(5'b10010, 32'd0, 25'h3, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        start    = 1'b0;
        chk("t4_ready_drop", {31'h0, in_ready}, 32'h0);
        chk("t4_done",       {31'h0, done}, 32'h1);
        @(negedge clk);
        chk("t4_idle",   {31'h0, busy}, 32'h0);
        chk("t4_b2b_we", we_run_max, 32'd4);

        // Reset while a second request is being accepted.
        start_burst(8'h50, 9'd3);
        send(5'b10111, 32'd9, 25'h0, 1'b1);
        @(negedge clk);
        in_valid = 1'b1; in_opcode = 5'b10010; in_imm = 32'd3; in_base = 25'h0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        check_reset("midrst");
        start_burst(8'h60, 9'd1);
        send(5'b11111, 32'h1234_5678, 25'h0F0_F0F0, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("t5_done", {31'h0, done}, 32'h1);
        chk("t5_addr", {24'h0, mem_addr}, 32'h60);
        wait_idle();

        chk("sb_drained", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
